// File: rtl/qif_sweep_scheduler.sv
// qif_sweep_scheduler: time-multiplexes NUM_NEURONS virtual QIF neurons over a
// single external update datapath. A divided tick starts a sweep; each neuron
// is issued, awaited, and written back in turn, and the sweep's spike flags are
// published with a one-cycle spike_valid pulse.
module qif_sweep_scheduler #(
    parameter int          NUM_NEURONS = 4,
    parameter logic [23:0] TICK_DIV    = 24'd10_000_000,
    parameter logic [7:0]  V_INIT      = 8'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_NEURONS*8-1:0] i_syn_bus,
    input  logic [2:0]               mon_sel,
    output logic                     dp_valid,
    output logic [7:0]               dp_v_in,
    output logic [7:0]               dp_i_in,
    input  logic                     dp_ready,
    input  logic                     dp_done,
    input  logic [7:0]               dp_v_out,
    input  logic                     dp_spike,
    output logic [7:0]               v_mon,
    output logic [NUM_NEURONS-1:0]   spike_vec,
    output logic                     spike_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int                IDXW      = $clog2(NUM_NEURONS);
    localparam logic [23:0]       TICK_LAST = TICK_DIV - 24'd1;
    localparam logic [IDXW-1:0]   IDX_LAST  = IDXW'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t                 state;
    logic [23:0]            cnt;
    logic                   tick;
    logic [7:0]             v    [NUM_NEURONS];
    logic [7:0]             snap [NUM_NEURONS];
    logic [IDXW-1:0]        idx;
    logic [IDXW-1:0]        idx_nxt;
    logic [7:0]             res_v;
    logic                   res_spk;
    logic [NUM_NEURONS-1:0] spike_next;
    logic [NUM_NEURONS-1:0] spike_merged;
    logic [7:0]             mon_val;

    assign idx_nxt = idx + IDXW'(1);
    assign busy    = (state != IDLE);

    // Spike vector as it will look once the current neuron's flag is written.
    always_comb begin
        spike_merged      = spike_next;
        spike_merged[idx] = res_spk;
    end

    // Monitor mux; out-of-range selections read as zero.
    always_comb begin
        mon_val = '0;
        for (int k = 0; k < NUM_NEURONS; k++)
            if (mon_sel == 3'(k)) mon_val = v[k];
    end

    // Time-step divider: registered one-cycle tick every TICK_DIV enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cnt == TICK_LAST) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + 24'd1;
                end
            end
        end
    end

    // Sweep sequencer: issue each neuron, wait for its result, write it back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            dp_valid    <= 1'b0;
            dp_v_in     <= '0;
            dp_i_in     <= '0;
            res_v       <= '0;
            res_spk     <= 1'b0;
            spike_next  <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v[k]    <= V_INIT;
                snap[k] <= '0;
            end
        end else begin
            spike_valid <= 1'b0;
            // A tick landing anywhere but IDLE (DONE included) is lost.
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    for (int k = 0; k < NUM_NEURONS; k++)
                        snap[k] <= i_syn_bus[8*k +: 8];
                    idx      <= '0;
                    dp_valid <= 1'b1;
                    dp_v_in  <= v[0];
                    dp_i_in  <= i_syn_bus[7:0];
                    state    <= ISSUE;
                end
                ISSUE: if (dp_ready) begin
                    dp_valid <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (dp_done) begin
                    res_v   <= dp_v_out;
                    res_spk <= dp_spike;
                    state   <= WRITE;
                end
                WRITE: begin
                    v[idx]          <= res_v;
                    spike_next[idx] <= res_spk;
                    if (idx == IDX_LAST) begin
                        // Publish on entry so spike_valid spans exactly the DONE cycle.
                        spike_vec   <= spike_merged;
                        spike_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx      <= idx_nxt;
                        dp_valid <= 1'b1;
                        dp_v_in  <= v[idx_nxt];
                        dp_i_in  <= snap[idx_nxt];
                        state    <= ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered membrane monitor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_mon <= '0;
        else     v_mon <= mon_val;
    end

endmodule
